// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, preloadable instruction memory,
// IDLE/RUN/HALT control and a registered Instruction/Address/valid output.
module instruction_fetch #(
    parameter int          IMEM_WORDS = 64,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stall,
    input  logic                          PCSrc,
    input  logic [63:0]                   BranchAddress,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_WORDS)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   Instruction,
    output logic [63:0]                   Address,
    output logic                          valid,
    output logic                          halted,
    output logic                          misaligned
);

    localparam int AW = $clog2(IMEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;
    logic [31:0] imem_q [IMEM_WORDS];

    logic        in_range;
    logic        redirect;
    logic [31:0] rd_word;

    // Word index fits the memory only when every PC bit above it is zero.
    assign in_range = (pc_q[63:AW+2] == '0);
    // A branch is honoured in RUN and HALT; IDLE ignores it.
    assign redirect = PCSrc && (state_q != S_IDLE);
    // Read happens before this edge's write lands, so a colliding fetch sees old data.
    assign rd_word  = imem_q[pc_q[AW+1:2]];

    // Preload port; memory is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (imem_we && !reset) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; redirect beats stall, out-of-range fetch halts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (PCSrc)                      state_d = S_RUN;
                else if (!stall && !in_range)   state_d = S_HALT;
            end
            S_HALT: if (PCSrc) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        halted = (state_q == S_HALT);
    end

    // Datapath next-state: redirect inserts a bubble, RUN fetches or holds on stall.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        if (redirect) begin
            pc_d    = {BranchAddress[63:2], 2'b00};
            instr_d = 32'h0;
            valid_d = 1'b0;
            mis_d   = mis_q | (|BranchAddress[1:0]);
        end else if (state_q == S_RUN && !stall) begin
            if (in_range) begin
                instr_d = rd_word;
                addr_d  = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + 64'd4;
            end else begin
                instr_d = 32'h0;
                valid_d = 1'b0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            addr_q  <= 64'h0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    assign Instruction = instr_q;
    assign Address     = addr_q;
    assign valid       = valid_q;
    assign misaligned  = mis_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// stimulus, all compared against a cycle-level behavioural model.
module tb_instruction_fetch;

    localparam int WORDS = 64;
    localparam int AW    = $clog2(WORDS);

    logic          clk = 1'b0;
    logic          reset = 1'b0, start = 1'b0, stall = 1'b0, PCSrc = 1'b0;
    logic [63:0]   BranchAddress = '0;
    logic          imem_we = 1'b0;
    logic [AW-1:0] imem_waddr = '0;
    logic [31:0]   imem_wdata = '0;
    logic [31:0]   Instruction;
    logic [63:0]   Address;
    logic          valid, halted, misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(.IMEM_WORDS(WORDS), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .PCSrc(PCSrc),
        .BranchAddress(BranchAddress), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .Instruction(Instruction), .Address(Address),
        .valid(valid), .halted(halted), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0=idle, 1=running, 2=halted.
    int          m_mode = 0;
    logic [63:0] m_pc = '0, m_addr = '0;
    logic [31:0] m_instr = '0;
    logic        m_valid = 1'b0, m_mis = 1'b0;
    logic [31:0] mem_m [WORDS];

    wire [98:0] dut_bus = {Instruction, Address, valid, halted, misaligned};

    function automatic logic [98:0] exp_bus();
        return {m_instr, m_addr, m_valid, (m_mode == 2), m_mis};
    endfunction

    task automatic model_step();
        if (reset) begin
            m_mode = 0; m_pc = 64'h0; m_instr = 0; m_addr = 0; m_valid = 0; m_mis = 0;
        end else begin
            if (m_mode == 0) begin
                if (start) m_mode = 1;
            end else if (PCSrc) begin
                if (BranchAddress % 4 != 0) m_mis = 1;
                m_pc = BranchAddress - (BranchAddress % 4);
                m_instr = 0; m_valid = 0; m_mode = 1;
            end else if (m_mode == 1 && !stall) begin
                if (m_pc / 4 < WORDS) begin
                    m_instr = mem_m[m_pc / 4]; m_addr = m_pc; m_valid = 1; m_pc = m_pc + 4;
                end else begin
                    m_mode = 2; m_valid = 0; m_instr = 0;
                end
            end
            if (imem_we) mem_m[imem_waddr] = imem_wdata;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; stall = 0; PCSrc = 0; imem_we = 0;
    endtask

    task automatic do_reset();
        idle_inputs(); reset = 1; tick(); reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; start = 1; PCSrc = 1; stall = 1; BranchAddress = 64'h44;
        tick();
        n_checks++;
        if (dut_bus !== 99'h0)
            begin n_fail++; $display("FAIL reset_state: got %h want 0", dut_bus); end
        idle_inputs();
        // Fill the whole memory while idle so model and DUT agree everywhere.
        for (int i = 0; i < WORDS; i++) begin
            imem_we = 1; imem_waddr = AW'(i); imem_wdata = $urandom; tick();
        end
        imem_we = 0;
        tick();
        n_checks++;
        if (dut_bus !== exp_bus() || valid !== 1'b0)
            begin n_fail++; $display("FAIL idle_after_preload: got %h want %h", dut_bus, exp_bus()); end
    endtask

    task automatic test_sequential();
        logic [31:0] w [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom; imem_we = 1; imem_waddr = AW'(i); imem_wdata = w[i]; tick();
        end
        imem_we = 0;
        start = 1; tick(); start = 0;
        n_checks++;
        if (valid !== 1'b0)
            begin n_fail++; $display("FAIL start_edge_valid: got %b want 0", valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (Address !== 64'(4 * i) || Instruction !== w[i] || valid !== 1'b1 || dut_bus !== exp_bus())
                begin n_fail++; $display("FAIL seq_fetch%0d: got addr %h instr %h v %b want addr %h instr %h v 1",
                                         i, Address, Instruction, valid, 4 * i, w[i]); end
        end
    endtask

    task automatic test_stall_and_branch();
        do_reset();
        start = 1; tick(); start = 0;
        tick(); tick();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (Address !== 64'h4 || Instruction !== mem_m[1] || valid !== 1'b1)
                begin n_fail++; $display("FAIL stall_hold%0d: got addr %h instr %h want addr 4 instr %h",
                                         i, Address, Instruction, mem_m[1]); end
        end
        stall = 0; tick();
        n_checks++;
        if (Address !== 64'h8 || Instruction !== mem_m[2] || valid !== 1'b1)
            begin n_fail++; $display("FAIL stall_release: got addr %h instr %h want addr 8 instr %h",
                                     Address, Instruction, mem_m[2]); end
        // Redirect wins over stall and leaves one bubble.
        PCSrc = 1; BranchAddress = 64'h20; stall = 1; tick();
        n_checks++;
        if (valid !== 1'b0 || Instruction !== 32'h0)
            begin n_fail++; $display("FAIL branch_bubble: got v %b instr %h want v 0 instr 0", valid, Instruction); end
        PCSrc = 0; stall = 0; tick();
        n_checks++;
        if (Address !== 64'h20 || Instruction !== mem_m[8] || valid !== 1'b1 || dut_bus !== exp_bus())
            begin n_fail++; $display("FAIL branch_target: got addr %h instr %h want addr 20 instr %h",
                                     Address, Instruction, mem_m[8]); end
    endtask

    task automatic test_halt();
        do_reset();
        start = 1; tick(); start = 0;
        PCSrc = 1; BranchAddress = 64'((WORDS - 2) * 4); tick(); PCSrc = 0;
        tick(); tick();
        n_checks++;
        if (Address !== 64'((WORDS - 1) * 4) || valid !== 1'b1)
            begin n_fail++; $display("FAIL last_word: got addr %h v %b want addr %h v 1", Address, valid, (WORDS - 1) * 4); end
        tick();
        n_checks++;
        if (halted !== 1'b1 || valid !== 1'b0 || Instruction !== 32'h0)
            begin n_fail++; $display("FAIL enter_halt: got h %b v %b instr %h want h 1 v 0 instr 0", halted, valid, Instruction); end
        tick();
        n_checks++;
        if (halted !== 1'b1 || dut_bus !== exp_bus())
            begin n_fail++; $display("FAIL stay_halt: got %h want %h", dut_bus, exp_bus()); end
        // Redirect to an out-of-range target: one RUN cycle, then HALT again.
        PCSrc = 1; BranchAddress = 64'h1000; tick(); PCSrc = 0;
        n_checks++;
        if (halted !== 1'b0 || valid !== 1'b0)
            begin n_fail++; $display("FAIL halt_redirect_oor: got h %b v %b want h 0 v 0", halted, valid); end
        tick();
        n_checks++;
        if (halted !== 1'b1)
            begin n_fail++; $display("FAIL rehalt: got h %b want 1", halted); end
        PCSrc = 1; BranchAddress = 64'h0; tick(); PCSrc = 0;
        n_checks++;
        if (halted !== 1'b0 || valid !== 1'b0)
            begin n_fail++; $display("FAIL halt_exit: got h %b v %b want h 0 v 0", halted, valid); end
        tick();
        n_checks++;
        if (Address !== 64'h0 || valid !== 1'b1 || Instruction !== mem_m[0])
            begin n_fail++; $display("FAIL halt_resume: got addr %h v %b want addr 0 v 1", Address, valid); end
    endtask

    task automatic test_misaligned();
        PCSrc = 1; BranchAddress = 64'h13; tick(); PCSrc = 0;
        n_checks++;
        if (misaligned !== 1'b1)
            begin n_fail++; $display("FAIL mis_set: got %b want 1", misaligned); end
        tick();
        n_checks++;
        if (Address !== 64'h10 || Instruction !== mem_m[4] || valid !== 1'b1)
            begin n_fail++; $display("FAIL mis_target: got addr %h want addr 10", Address); end
        PCSrc = 1; BranchAddress = 64'h8; tick(); PCSrc = 0; tick(); tick();
        n_checks++;
        if (misaligned !== 1'b1 || dut_bus !== exp_bus())
            begin n_fail++; $display("FAIL mis_sticky: got %h want %h", dut_bus, exp_bus()); end
        do_reset();
        n_checks++;
        if (misaligned !== 1'b0)
            begin n_fail++; $display("FAIL mis_clear: got %b want 0", misaligned); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        start = 1; tick(); start = 0;
        tick(); tick(); tick();
        n_checks++;
        if (Address !== 64'h8 || valid !== 1'b1)
            begin n_fail++; $display("FAIL pre_reset: got addr %h v %b want addr 8 v 1", Address, valid); end
        reset = 1; PCSrc = 1; imem_we = 1; imem_waddr = 0; imem_wdata = ~mem_m[0]; tick();
        reset = 0; imem_we = 0;
        n_checks++;
        if (dut_bus !== 99'h0)
            begin n_fail++; $display("FAIL reset_midrun: got %h want 0", dut_bus); end
        BranchAddress = 64'h40;
        for (int i = 0; i < 3; i++) tick();
        PCSrc = 0;
        n_checks++;
        if (dut_bus !== 99'h0)
            begin n_fail++; $display("FAIL idle_ignores_pcsrc: got %h want 0", dut_bus); end
        start = 1; tick(); start = 0; tick();
        n_checks++;
        if (Address !== 64'h0 || valid !== 1'b1 || dut_bus !== exp_bus())
            begin n_fail++; $display("FAIL restart_pc: got addr %h v %b want addr 0 v 1", Address, valid); end
    endtask

    task automatic test_mem_collision();
        logic [31:0] old_w, new_w;
        do_reset();
        start = 1; tick(); start = 0; tick();
        old_w = mem_m[1]; new_w = ~old_w;
        imem_we = 1; imem_waddr = 1; imem_wdata = new_w; tick(); imem_we = 0;
        n_checks++;
        if (Instruction !== old_w || Address !== 64'h4)
            begin n_fail++; $display("FAIL collide_old: got %h want %h", Instruction, old_w); end
        PCSrc = 1; BranchAddress = 64'h4; tick(); PCSrc = 0; tick();
        n_checks++;
        if (Instruction !== new_w)
            begin n_fail++; $display("FAIL collide_new: got %h want %h", Instruction, new_w); end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 63) == 0);
            start   = ($urandom_range(0, 7) == 0);
            stall   = ($urandom_range(0, 3) == 0);
            PCSrc   = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 7))
                0:       BranchAddress = {$urandom, $urandom};
                1:       BranchAddress = {32'h0, $urandom};
                default: BranchAddress = 64'($urandom_range(0, WORDS * 4 + 15));
            endcase
            imem_we    = ($urandom_range(0, 3) == 0);
            imem_waddr = AW'($urandom);
            imem_wdata = $urandom;
            tick();
            n_checks++;
            if (dut_bus !== exp_bus()) begin
                n_fail++;
                if (bad < 10) $display("FAIL random_cycle%0d: got %h want %h", i, dut_bus, exp_bus());
                bad++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_and_branch();
        test_halt();
        test_misaligned();
        test_reset_midrun();
        test_mem_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
